// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the clock-divider measurement sequencer:
// default widths, the minimum legal divide ratio and the FSM state encoding.
package div_ctrl_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int RATIO_W_DEF = 8;
  localparam int MIN_RATIO   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/div_tick_gen.sv
// Divide-by-ratio phase counter. The tick is combinational so that it lines up
// with the cycle in which the phase wraps, which is the cycle the sequencer counts it.
module div_tick_gen #(
  parameter int RATIO_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [RATIO_W-1:0] ratio,
  output logic               tick,
  output logic [RATIO_W-1:0] phase
);

  logic [RATIO_W-1:0] phase_q, phase_d;
  logic               last_hit;

  // next phase: clear has priority, otherwise advance and wrap at ratio-1
  always_comb begin
    last_hit = (phase_q == (ratio - RATIO_W'(1)));
    phase_d  = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      if (last_hit) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + RATIO_W'(1);
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tick  = en & ~clr & last_hit;
  assign phase = phase_q;

endmodule

// File: rtl/divider_seq_ctrl.sv
// Bounded measurement run sequencer: latches ratio/window on start, runs the tick
// generator for exactly 'window' clocks, counts clocks and ticks, then self-checks.
module divider_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int RATIO_W = RATIO_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [RATIO_W-1:0] ratio,
  input  logic [CNT_W-1:0]   window,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               pass,
  output logic               div_tick,
  output logic [CNT_W-1:0]   clk_cnt,
  output logic [CNT_W-1:0]   clk_div_cnt
);

  localparam logic [RATIO_W-1:0] MinRatio = RATIO_W'(MIN_RATIO);
  localparam int                 PW       = CNT_W + RATIO_W;

  state_e             state_q, state_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0]   window_q, window_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [CNT_W-1:0]   clk_div_cnt_q, clk_div_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               pass_q, pass_d;

  logic               gen_clr, gen_en, gen_tick;
  logic [RATIO_W-1:0] gen_phase;
  logic               cfg_bad;
  logic [PW-1:0]      prod, recon;
  logic               check_ok;

  // an abort cycle is not counted, so the phase must not advance either
  assign gen_clr = (state_q == ST_ARM);
  assign gen_en  = (state_q == ST_RUN) & ~abort;

  div_tick_gen #(.RATIO_W(RATIO_W)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (gen_clr),
    .en    (gen_en),
    .ratio (ratio_q),
    .tick  (gen_tick),
    .phase (gen_phase)
  );

  assign cfg_bad  = (ratio < MinRatio) | (window == '0);
  assign prod     = {{RATIO_W{1'b0}}, clk_div_cnt_q} * {{CNT_W{1'b0}}, ratio_q};
  assign recon    = prod + {{CNT_W{1'b0}}, gen_phase};
  assign check_ok = (recon == {{RATIO_W{1'b0}}, window_q});

  // sequencer next-state, counter and status logic
  always_comb begin
    state_d       = state_q;
    ratio_d       = ratio_q;
    window_d      = window_q;
    clk_cnt_d     = clk_cnt_q;
    clk_div_cnt_d = clk_div_cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    pass_d        = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d   = 1'b1;
            pass_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            ratio_d       = ratio;
            window_d      = window;
            clk_cnt_d     = '0;
            clk_div_cnt_d = '0;
            err_d         = 1'b0;
            pass_d        = 1'b0;
            busy_d        = 1'b1;
            state_d       = ST_ARM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (abort) begin
          err_d   = 1'b1;
          pass_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          err_d   = 1'b1;
          pass_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
          if (gen_tick) begin
            clk_div_cnt_d = clk_div_cnt_q + CNT_W'(1);
          end else begin
            clk_div_cnt_d = clk_div_cnt_q;
          end
          if (clk_cnt_d == window_q) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_CHECK: begin
        pass_d  = check_ok;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // all sequencer state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ratio_q       <= '0;
      window_q      <= '0;
      clk_cnt_q     <= '0;
      clk_div_cnt_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ratio_q       <= ratio_d;
      window_q      <= window_d;
      clk_cnt_q     <= clk_cnt_d;
      clk_div_cnt_q <= clk_div_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      pass_q        <= pass_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign pass        = pass_q;
  assign div_tick    = gen_tick;
  assign clk_cnt     = clk_cnt_q;
  assign clk_div_cnt = clk_div_cnt_q;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Randomized and directed bench for divider_seq_ctrl against a run-level model
// (latency, counts and flags derived arithmetically from ratio, window and abort cycle).
module tb_divider_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  ratio;
  logic [31:0] window;
  logic        abort;
  logic        busy, done, err, pass, div_tick;
  logic [31:0] clk_cnt, clk_div_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt = 0;
  int m_div = 0;

  divider_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ratio       (ratio),
    .window      (window),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .pass        (pass),
    .div_tick    (div_tick),
    .clk_cnt     (clk_cnt),
    .clk_div_cnt (clk_div_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One run. Cycle 0 is the cycle start is presented in IDLE; abort_k and
  // restart_k are cycle offsets from it (0 = not used).
  task automatic do_run(input int r, input int w, input int abort_k, input int restart_k,
                        input string nm);
    bit legal;
    int lat, runc, e_cnt, e_div, e_err, e_pass, done_k, ticks, busy_bad;
    legal = (r >= 2) && (w >= 1);
    if (!legal) begin
      lat = 1; e_cnt = m_cnt; e_div = m_div; e_err = 1; e_pass = 0;
    end else if (abort_k >= 1 && abort_k <= w + 1) begin
      runc  = (abort_k >= 2) ? abort_k - 2 : 0;
      lat   = abort_k + 1;
      e_cnt = runc; e_div = runc / r; e_err = 1; e_pass = 0;
    end else begin
      lat = w + 3; e_cnt = w; e_div = w / r; e_err = 0; e_pass = 1;
    end
    m_cnt = e_cnt;
    m_div = e_div;

    @(negedge clk);
    start = 1'b1; ratio = r[7:0]; window = w; abort = 1'b0;
    done_k = 0; ticks = 0; busy_bad = 0;
    for (int k = 1; k <= w + 8 && done_k == 0; k++) begin
      @(negedge clk);
      start = (k == restart_k);
      if (k == restart_k) begin
        ratio = 8'd3; window = 32'd5;
      end else begin
        ratio = 8'($urandom); window = $urandom;
      end
      abort = (k == abort_k);
      #1;
      if (busy != (legal && k < lat)) busy_bad++;
      if (div_tick) ticks++;
      if (done) done_k = k;
    end
    check_eq({nm, " done_lat"}, done_k, lat);
    check_eq({nm, " busy_bad"}, busy_bad, 0);
    check_eq({nm, " ticks"}, ticks, legal ? e_div : 0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check_eq({nm, " done_pulse"}, int'(done), 0);
    check_eq({nm, " clk_cnt"}, longint'(clk_cnt), e_cnt);
    check_eq({nm, " clk_div_cnt"}, longint'(clk_div_cnt), e_div);
    check_eq({nm, " err"}, int'(err), e_err);
    check_eq({nm, " pass"}, int'(pass), e_pass);
  endtask

  initial begin
    int r, w, ak, rk;
    rst = 1'b1; start = 1'b0; ratio = 8'd0; window = 32'd0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst busy", int'(busy), 0);
    check_eq("rst done", int'(done), 0);
    check_eq("rst err", int'(err), 0);
    check_eq("rst pass", int'(pass), 0);
    check_eq("rst tick", int'(div_tick), 0);
    check_eq("rst clk_cnt", longint'(clk_cnt), 0);
    check_eq("rst clk_div_cnt", longint'(clk_div_cnt), 0);
    rst = 1'b0;

    do_run(6, 1000, 0, 0, "t1");
    do_run(2, 1, 0, 0, "t2");
    do_run(1, 10, 0, 0, "t3a");
    do_run(6, 0, 0, 0, "t3b");
    do_run(6, 1000, 102, 0, "t4");
    do_run(6, 1000, 0, 500, "t5");
    do_run(5, 20, 1, 0, "arm_abort");
    do_run(255, 600, 0, 0, "r255");
    do_run(7, 30, 32, 0, "abort_in_check");

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1; ratio = 8'd6; window = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("t6 busy", int'(busy), 0);
    check_eq("t6 done", int'(done), 0);
    check_eq("t6 err", int'(err), 0);
    check_eq("t6 pass", int'(pass), 0);
    check_eq("t6 tick", int'(div_tick), 0);
    check_eq("t6 clk_cnt", longint'(clk_cnt), 0);
    check_eq("t6 clk_div_cnt", longint'(clk_div_cnt), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_div = 0;
    repeat (2) @(negedge clk);
    check_eq("t6 no_done", int'(done), 0);
    do_run(6, 1000, 0, 0, "t6_rerun");

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 12);
      if ($urandom_range(0, 9) == 0) r = $urandom_range(2, 255);
      w  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
      ak = ($urandom_range(0, 2) == 0) ? $urandom_range(1, w + 3) : 0;
      rk = ($urandom_range(0, 3) == 0) ? $urandom_range(2, w + 2) : 0;
      do_run(r, w, ak, rk, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
